bs_axil_slave_regs: RTL

- AXI4-Lite slave (responder) register file for the bs block's S00_AXI port.
- Accepts single-beat writes and reads from the AXI VIP master or the PS interconnect.
- Holds NUM_REGS 32-bit control/status registers and exposes them to user logic.
- Supports independent AW/W arrival, WSTRB byte enables, SLVERR on unmapped addresses, and full backpressure on B and R.

---
 rtl/bs_axil_pkg.sv | 20 ++
 rtl/bs_axil_rd_chan.sv | 85 ++++++++
 rtl/bs_axil_slave_regs.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bs_axil_pkg.sv
// Shared response codes, address geometry and FSM state types for the bs AXI4-Lite register slave.
package bs_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte address bits below this are ignored; registers are word-addressed.
  localparam int ADDR_LSB = 2;

  typedef enum logic {
    W_ACCEPT = 1'b0,
    W_RESP   = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_ACCEPT = 1'b0,
    R_RESP   = 1'b1
  } rd_state_t;

endpackage

// File: rtl/bs_axil_rd_chan.sv
// AXI4-Lite read channel: AR capture, register mux and R response, 1 cycle AR->R.
// ARREADY drops while R is pending; RDATA/RRESP hold until RREADY, one read outstanding.
module bs_axil_rd_chan
  import bs_axil_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int IDX_W        = 3,
  parameter int NUM_REGS     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [IDX_W-1:0]                 ar_idx,
  input  logic                             ar_valid,
  output logic                             ar_ready,
  output logic [C_DATA_WIDTH-1:0]          r_data,
  output logic [1:0]                       r_resp,
  output logic                             r_valid,
  input  logic                             r_ready,
  input  logic [NUM_REGS*C_DATA_WIDTH-1:0] reg_in
);

  rd_state_t                 state, state_nxt;
  logic                      arready_nxt;
  logic                      rvalid_nxt;
  logic [C_DATA_WIDTH-1:0]   rdata_nxt;
  logic [1:0]                rresp_nxt;
  logic [C_DATA_WIDTH-1:0]   rd_word;
  logic                      rd_hit;

  always_comb begin
    rd_word = '0;
    rd_hit  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_word = reg_in[i*C_DATA_WIDTH +: C_DATA_WIDTH];
        rd_hit  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    arready_nxt = ar_ready;
    rvalid_nxt  = r_valid;
    rdata_nxt   = r_data;
    rresp_nxt   = r_resp;
    case (state)
      R_ACCEPT: begin
        arready_nxt = 1'b1;
        if (ar_valid && ar_ready) begin
          rdata_nxt   = rd_hit ? rd_word : '0;
          rresp_nxt   = rd_hit ? RESP_OKAY : RESP_SLVERR;
          rvalid_nxt  = 1'b1;
          arready_nxt = 1'b0;
          state_nxt   = R_RESP;
        end
      end
      R_RESP: begin
        if (r_ready) begin
          rvalid_nxt  = 1'b0;
          arready_nxt = 1'b1;
          state_nxt   = R_ACCEPT;
        end
      end
      default: state_nxt = R_ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= R_ACCEPT;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_resp   <= RESP_OKAY;
    end else begin
      state    <= state_nxt;
      ar_ready <= arready_nxt;
      r_valid  <= rvalid_nxt;
      r_data   <= rdata_nxt;
      r_resp   <= rresp_nxt;
    end
  end

endmodule

// File: rtl/bs_axil_slave_regs.sv
// AXI4-Lite register file slave: AW/W in any order, B and R one cycle after the completing handshake.
// Readies drop while a response is pending; B/R hold until BREADY/RREADY, one write and one read outstanding.
module bs_axil_slave_regs
  import bs_axil_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 5,
  parameter int NUM_REGS     = 4
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic [C_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                       S_AXI_AWPROT,
  input  logic                             S_AXI_AWVALID,
  output logic                             S_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                             S_AXI_WVALID,
  output logic                             S_AXI_WREADY,
  output logic [1:0]                       S_AXI_BRESP,
  output logic                             S_AXI_BVALID,
  input  logic                             S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                       S_AXI_ARPROT,
  input  logic                             S_AXI_ARVALID,
  output logic                             S_AXI_ARREADY,
  output logic [C_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                       S_AXI_RRESP,
  output logic                             S_AXI_RVALID,
  input  logic                             S_AXI_RREADY,
  output logic [NUM_REGS*C_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]              reg_wr_pulse
);

  localparam int IDX_W  = C_ADDR_WIDTH - ADDR_LSB;
  localparam int STRB_W = C_DATA_WIDTH / 8;

  wr_state_t                 w_state, w_state_nxt;
  logic                      aw_held, aw_held_nxt;
  logic                      w_held, w_held_nxt;
  logic [IDX_W-1:0]          aw_idx, aw_idx_nxt;
  logic [C_DATA_WIDTH-1:0]   wdata_q, wdata_nxt;
  logic [STRB_W-1:0]         wstrb_q, wstrb_nxt;
  logic                      awready_nxt, wready_nxt, bvalid_nxt;
  logic [1:0]                bresp_nxt;

  logic                      aw_hs, w_hs;
  logic                      wr_commit;
  logic                      wr_in_range;
  logic [IDX_W-1:0]          wr_idx;
  logic [C_DATA_WIDTH-1:0]   wr_data;
  logic [STRB_W-1:0]         wr_strb;

  logic                      unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;

  // Whichever half arrives on the completing edge is taken straight from the bus.
  assign wr_idx      = aw_held ? aw_idx  : S_AXI_AWADDR[C_ADDR_WIDTH-1:ADDR_LSB];
  assign wr_data     = w_held  ? wdata_q : S_AXI_WDATA;
  assign wr_strb     = w_held  ? wstrb_q : S_AXI_WSTRB;
  assign wr_in_range = (int'(wr_idx) < NUM_REGS);

  always_comb begin
    w_state_nxt = w_state;
    aw_held_nxt = aw_held;
    w_held_nxt  = w_held;
    aw_idx_nxt  = aw_idx;
    wdata_nxt   = wdata_q;
    wstrb_nxt   = wstrb_q;
    awready_nxt = S_AXI_AWREADY;
    wready_nxt  = S_AXI_WREADY;
    bvalid_nxt  = S_AXI_BVALID;
    bresp_nxt   = S_AXI_BRESP;
    wr_commit   = 1'b0;
    case (w_state)
      W_ACCEPT: begin
        if (aw_hs) begin
          aw_held_nxt = 1'b1;
          aw_idx_nxt  = S_AXI_AWADDR[C_ADDR_WIDTH-1:ADDR_LSB];
        end
        if (w_hs) begin
          w_held_nxt = 1'b1;
          wdata_nxt  = S_AXI_WDATA;
          wstrb_nxt  = S_AXI_WSTRB;
        end
        if (aw_held_nxt && w_held_nxt) begin
          wr_commit   = 1'b1;
          bresp_nxt   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
          bvalid_nxt  = 1'b1;
          aw_held_nxt = 1'b0;
          w_held_nxt  = 1'b0;
          awready_nxt = 1'b0;
          wready_nxt  = 1'b0;
          w_state_nxt = W_RESP;
        end else begin
          awready_nxt = !aw_held_nxt;
          wready_nxt  = !w_held_nxt;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_nxt  = 1'b0;
          awready_nxt = 1'b1;
          wready_nxt  = 1'b1;
          w_state_nxt = W_ACCEPT;
        end
      end
      default: w_state_nxt = W_ACCEPT;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state       <= W_ACCEPT;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      w_state       <= w_state_nxt;
      aw_held       <= aw_held_nxt;
      w_held        <= w_held_nxt;
      aw_idx        <= aw_idx_nxt;
      wdata_q       <= wdata_nxt;
      wstrb_q       <= wstrb_nxt;
      S_AXI_AWREADY <= awready_nxt;
      S_AXI_WREADY  <= wready_nxt;
      S_AXI_BVALID  <= bvalid_nxt;
      S_AXI_BRESP   <= bresp_nxt;
    end
  end

  // Strobe fires for every in-range write, even with no byte lanes enabled.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      reg_out      <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (wr_commit && wr_in_range) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_idx == IDX_W'(i)) begin
            reg_wr_pulse[i] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (wr_strb[b]) begin
                reg_out[i*C_DATA_WIDTH + b*8 +: 8] <= wr_data[b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end

  bs_axil_rd_chan #(
    .C_DATA_WIDTH (C_DATA_WIDTH),
    .IDX_W        (IDX_W),
    .NUM_REGS     (NUM_REGS)
  ) u_rd_chan (
    .clk      (ACLK),
    .rst      (ARESET),
    .ar_idx   (S_AXI_ARADDR[C_ADDR_WIDTH-1:ADDR_LSB]),
    .ar_valid (S_AXI_ARVALID),
    .ar_ready (S_AXI_ARREADY),
    .r_data   (S_AXI_RDATA),
    .r_resp   (S_AXI_RRESP),
    .r_valid  (S_AXI_RVALID),
    .r_ready  (S_AXI_RREADY),
    .reg_in   (reg_out)
  );

endmodule
